// File: rtl/stack_down_oob_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : stack_down_oob_arb_if
//  Description : Bundle of the manager-side OOB request ports and the
//                stack-side forwarded beat of the down-stream OOB arbiter.
//                slave  : view taken by the arbiter itself.
//                master : view taken by the surrounding managers/stack.
//  Signals     : mgr__std__oob_valid/ready  per-manager handshake
//                mgr__std__oob_cntl/type/data packed per-manager beat,
//                                             manager i at [i*W +: W]
//                std__stk__oob_valid, stk__std__oob_ready  stack handshake
//                std__stk__oob_cntl/type/data/mgrId       forwarded beat
//  Revision    : 1.0 - initial release
// ============================================================================
interface stack_down_oob_arb_if #(
    parameter int NUM_MGR = 4,
    parameter int CNTL_W  = 2,
    parameter int TYPE_W  = 4,
    parameter int DATA_W  = 64
);
    localparam int MGR_W = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1;

    logic [NUM_MGR-1:0]        mgr__std__oob_valid;
    logic [NUM_MGR-1:0]        std__mgr__oob_ready;
    logic [NUM_MGR*CNTL_W-1:0] mgr__std__oob_cntl;
    logic [NUM_MGR*TYPE_W-1:0] mgr__std__oob_type;
    logic [NUM_MGR*DATA_W-1:0] mgr__std__oob_data;

    logic                      std__stk__oob_valid;
    logic                      stk__std__oob_ready;
    logic [CNTL_W-1:0]         std__stk__oob_cntl;
    logic [TYPE_W-1:0]         std__stk__oob_type;
    logic [DATA_W-1:0]         std__stk__oob_data;
    logic [MGR_W-1:0]          std__stk__oob_mgrId;

    modport slave (
        input  mgr__std__oob_valid,
        output std__mgr__oob_ready,
        input  mgr__std__oob_cntl,
        input  mgr__std__oob_type,
        input  mgr__std__oob_data,
        output std__stk__oob_valid,
        input  stk__std__oob_ready,
        output std__stk__oob_cntl,
        output std__stk__oob_type,
        output std__stk__oob_data,
        output std__stk__oob_mgrId
    );

    modport master (
        output mgr__std__oob_valid,
        input  std__mgr__oob_ready,
        output mgr__std__oob_cntl,
        output mgr__std__oob_type,
        output mgr__std__oob_data,
        input  std__stk__oob_valid,
        output stk__std__oob_ready,
        input  std__stk__oob_cntl,
        input  std__stk__oob_type,
        input  std__stk__oob_data,
        input  std__stk__oob_mgrId
    );
endinterface
`default_nettype wire

// File: rtl/stack_down_oob_arb.sv
`default_nettype none
// ============================================================================
//  Module      : stack_down_oob_arb
//  Description : Round-robin, packet-locked arbiter merging NUM_MGR manager
//                OOB request streams into one registered stack-side stream.
//                A SOM locks the winner until its EOM; single-beat packets
//                (SOM_EOM) release immediately. Out-of-place beats raise a
//                sticky protocol error.
//  Ports       : clk                    rising-edge clock
//                reset_poweron          synchronous, active-low reset
//                bus (slave modport)    manager requests / stack output
//                std__sys__oob_protErr  sticky protocol-error flag
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_down_oob_arb #(
    parameter int NUM_MGR = 4,
    parameter int CNTL_W  = 2,
    parameter int TYPE_W  = 4,
    parameter int DATA_W  = 64
) (
    input  wire logic             clk,
    input  wire logic             reset_poweron,
    stack_down_oob_arb_if.slave   bus,
    output logic                  std__sys__oob_protErr
);
    localparam int MGR_W = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1;

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_pkt  = 1'b1;

    // ------------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------------
    logic [0:0]        state_q,     state_d;
    logic [MGR_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [MGR_W-1:0]  lock_q,      lock_d;
    logic              prot_err_q,  prot_err_d;
    logic              out_valid_q, out_valid_d;
    logic [CNTL_W-1:0] out_cntl_q,  out_cntl_d;
    logic [TYPE_W-1:0] out_type_q,  out_type_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [MGR_W-1:0]  out_mgr_q,   out_mgr_d;

    // ------------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------------
    logic [MGR_W-1:0]   w_grant;
    logic               w_grant_vld;
    logic               w_can_accept;
    logic               w_fire;
    logic               w_fwd;
    logic [NUM_MGR-1:0] w_ready;
    logic [CNTL_W-1:0]  w_cntl;
    logic [TYPE_W-1:0]  w_type;
    logic [DATA_W-1:0]  w_data;
    logic               w_sop;
    logic               w_eop;

    // The output slot can take a new beat when empty or being drained now.
    assign w_can_accept = !out_valid_q || bus.stk__std__oob_ready;

    assign w_cntl = bus.mgr__std__oob_cntl[w_grant*CNTL_W +: CNTL_W];
    assign w_type = bus.mgr__std__oob_type[w_grant*TYPE_W +: TYPE_W];
    assign w_data = bus.mgr__std__oob_data[w_grant*DATA_W +: DATA_W];

    // cntl encoding: bit0 marks start-class (SOM, SOM_EOM),
    // bit1 marks end-class (EOM, SOM_EOM); 2'b00 is MOM.
    assign w_sop = w_cntl[0];
    assign w_eop = w_cntl[1];

    assign w_fire = reset_poweron && w_grant_vld && w_can_accept &&
                    bus.mgr__std__oob_valid[w_grant];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin : p_state_reg
        if (!reset_poweron) begin
            state_q <= c_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin : p_state_next
        state_d = state_q;
        case (state_q)
            c_idle:  if (w_fire && w_sop && !w_eop) state_d = c_pkt;
            c_pkt:   if (w_fire && w_eop)           state_d = c_idle;
            default: state_d = c_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (grant selection and per-manager ready)
    // In IDLE the search runs from rr_ptr upward; iterating the offset
    // downward lets the nearest requester overwrite farther ones. With no
    // requester the previous grant is kept. In PKT only the locked port is
    // eligible, whether or not it is currently presenting a beat.
    // ------------------------------------------------------------------------
    always_comb begin : p_fsm_out
        logic [MGR_W-1:0] v_idx;
        v_idx       = '0;
        w_grant     = lock_q;
        w_grant_vld = 1'b0;
        w_ready     = '0;
        if (state_q == c_idle) begin
            for (int k = NUM_MGR - 1; k >= 0; k--) begin
                v_idx = rr_ptr_q + MGR_W'(k);
                if (bus.mgr__std__oob_valid[v_idx]) begin
                    w_grant     = v_idx;
                    w_grant_vld = 1'b1;
                end
            end
        end else begin
            w_grant_vld = 1'b1;
        end
        // Reset gating keeps every ready low while reset_poweron is held.
        if (reset_poweron && w_grant_vld && w_can_accept) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------------
    always_comb begin : p_data_next
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        prot_err_d  = prot_err_q;
        w_fwd       = 1'b0;
        if (w_fire) begin
            if (state_q == c_idle) begin
                if (w_sop) begin
                    w_fwd  = 1'b1;
                    lock_d = w_grant;
                    if (w_eop) rr_ptr_d = w_grant + 1'b1;
                end else begin
                    // Stray MOM/EOM outside a packet: consumed and dropped,
                    // round-robin position untouched.
                    prot_err_d = 1'b1;
                end
            end else begin
                w_fwd = 1'b1;
                if (w_sop) prot_err_d = 1'b1;
                if (w_eop) rr_ptr_d = lock_q + 1'b1;
            end
        end

        out_valid_d = out_valid_q;
        out_cntl_d  = out_cntl_q;
        out_type_d  = out_type_q;
        out_data_d  = out_data_q;
        out_mgr_d   = out_mgr_q;
        if (w_fwd) begin
            out_valid_d = 1'b1;
            out_cntl_d  = w_cntl;
            out_type_d  = w_type;
            out_data_d  = w_data;
            out_mgr_d   = w_grant;
        end else if (bus.stk__std__oob_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin : p_data_reg
        if (!reset_poweron) begin
            rr_ptr_q    <= '0;
            lock_q      <= '0;
            prot_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_cntl_q  <= '0;
            out_type_q  <= '0;
            out_data_q  <= '0;
            out_mgr_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            prot_err_q  <= prot_err_d;
            out_valid_q <= out_valid_d;
            out_cntl_q  <= out_cntl_d;
            out_type_q  <= out_type_d;
            out_data_q  <= out_data_d;
            out_mgr_q   <= out_mgr_d;
        end
    end

    assign bus.std__mgr__oob_ready  = w_ready;
    assign bus.std__stk__oob_valid  = out_valid_q;
    assign bus.std__stk__oob_cntl   = out_cntl_q;
    assign bus.std__stk__oob_type   = out_type_q;
    assign bus.std__stk__oob_data   = out_data_q;
    assign bus.std__stk__oob_mgrId  = out_mgr_q;
    assign std__sys__oob_protErr    = prot_err_q;

endmodule
`default_nettype wire
